// File: rtl/fp_sub_seq.sv
// fp_sub_seq: multi-cycle IEEE-754 single-precision subtractor (out = a - b).
//
// This unit sits beside fp_adder in the FPU datapath. It takes one operand
// pair over a valid/ready handshake. Each pair walks through a fixed
// datapath FSM:
//   IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
// The result stays on out until the consumer accepts it.
//
// Parameters:
//   RNE : 1 = round to nearest even; 0 = truncate toward zero
//   FTZ : subnormal inputs and results are flushed to signed zero.
//         1 is the only supported value.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : operand pair a/b is valid
//   in_ready  : unit can accept operands (IDLE only)
//   a, b      : minuend and subtrahend, IEEE-754 single
//   out_valid : out holds a completed result
//   out_ready : consumer accepts the result
//   out       : a - b, IEEE-754 single
//   flags     : {invalid, overflow, underflow, inexact}.
//               This port exists only when FP_SUB_FLAGS_EN is defined.
//
// Optional feature macro: FP_SUB_FLAGS_EN
module fp_sub_seq #(
  parameter bit RNE = 1'b1,
  parameter bit FTZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out
`ifdef FP_SUB_FLAGS_EN
  ,
  output logic [3:0]  flags
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state, state_n;

  logic [31:0]       a_r, b_r;
  logic              sa, sb, sp;
  logic [7:0]        ea, eb, e_big, e_sum;
  logic [23:0]       ma, mb;
  logic [31:0]       sp_res, out_r;
  logic              s_big, s_small, r_sign, nzero, nuf;
  logic [26:0]       m_big, m_small, nm_r;
  logic [27:0]       sum_r;
  logic signed [9:0] ne_r;

  // State register. Reset wins over every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state logic and handshake outputs. The walk is fixed and does not
  // depend on the data, so latency is always the same.
  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_UNPACK;
      end
      S_UNPACK: state_n = S_ALIGN;
      S_ALIGN:  state_n = S_ADD;
      S_ADD:    state_n = S_NORM;
      S_NORM:   state_n = S_ROUND;
      S_ROUND:  state_n = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = S_IDLE;
      end
      default:  state_n = S_IDLE;
    endcase
  end

  // Unpack: classify both operands and resolve special cases up front.
  // b_r already carries the flipped sign, so everything after this stage is
  // an addition.
  logic [7:0]  ua_e, ub_e;
  logic        ua_nan, ub_nan, ua_inf, ub_inf, ua_zero, ub_zero, up_sp;
  logic [31:0] up_res;
  always_comb begin
    ua_e    = a_r[30:23];
    ub_e    = b_r[30:23];
    ua_nan  = (ua_e == 8'hFF) && (a_r[22:0] != 23'h0);
    ub_nan  = (ub_e == 8'hFF) && (b_r[22:0] != 23'h0);
    ua_inf  = (ua_e == 8'hFF) && (a_r[22:0] == 23'h0);
    ub_inf  = (ub_e == 8'hFF) && (b_r[22:0] == 23'h0);
    ua_zero = (ua_e == 8'h00) && (FTZ || (a_r[22:0] == 23'h0));
    ub_zero = (ub_e == 8'h00) && (FTZ || (b_r[22:0] == 23'h0));
    up_sp   = 1'b0;
    up_res  = 32'h0;
    if (ua_nan || ub_nan || (ua_inf && ub_inf && (a_r[31] != b_r[31]))) begin
      up_sp  = 1'b1;
      up_res = QNAN;
    end else if (ua_inf) begin
      up_sp  = 1'b1;
      up_res = {a_r[31], 8'hFF, 23'h0};
    end else if (ub_inf) begin
      up_sp  = 1'b1;
      up_res = {b_r[31], 8'hFF, 23'h0};
    end
  end

  // Align: put the larger magnitude first. Shift the smaller operand right.
  // The shift saturates at 27. Every bit shifted out is folded into sticky.
  logic        a_ge, al_lost;
  logic [7:0]  e_hi, e_lo, al_diff;
  logic [23:0] m_hi, m_lo;
  logic [4:0]  al_sh;
  logic [26:0] al_ext, al_shifted, al_mask;
  always_comb begin
    a_ge       = {ea, ma} >= {eb, mb};
    e_hi       = a_ge ? ea : eb;
    e_lo       = a_ge ? eb : ea;
    m_hi       = a_ge ? ma : mb;
    m_lo       = a_ge ? mb : ma;
    al_diff    = e_hi - e_lo;
    al_sh      = (al_diff > 8'd27) ? 5'd27 : al_diff[4:0];
    al_ext     = {m_lo, 3'b000};
    al_shifted = al_ext >> al_sh;
    al_mask    = ~(27'h7FF_FFFF << al_sh);
    al_lost    = |(al_ext & al_mask);
  end

  // Add/sub. The big operand is never smaller than the small one, so the
  // result is non-negative. An exact cancellation is forced to +0.
  logic        eff_sub;
  logic [27:0] add_sum;
  always_comb begin
    eff_sub = s_big ^ s_small;
    add_sum = eff_sub ? ({1'b0, m_big} - {1'b0, m_small})
                      : ({1'b0, m_big} + {1'b0, m_small});
  end

  // Normalise. On carry-out, shift right by one and keep the dropped bit
  // in sticky. Otherwise use a one-cycle leading-zero count and left shift.
  logic [4:0]        lzc;
  logic [26:0]       n_mant;
  logic signed [9:0] n_exp;
  always_comb begin
    lzc = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (sum_r[i]) lzc = 5'(26 - i);
    end
    if (sum_r[27]) begin
      n_mant = {sum_r[27:2], |sum_r[1:0]};
      n_exp  = $signed({2'b00, e_sum}) + 10'sd1;
    end else begin
      n_mant = sum_r[26:0] << lzc;
      n_exp  = $signed({2'b00, e_sum}) - $signed({5'b00000, lzc});
    end
  end

  // Round. When the round-up carries out of the mantissa, the fraction is
  // all zeros, so bits [23:1] give the same value as the shifted fraction.
  logic              rnd_up, rnd_ovf;
  logic [24:0]       rnd_m;
  logic signed [9:0] rnd_e;
  logic [22:0]       rnd_frac;
  logic [31:0]       rnd_res;
  always_comb begin
    rnd_up   = RNE && nm_r[2] && (nm_r[1] || nm_r[0] || nm_r[3]);
    rnd_m    = {1'b0, nm_r[26:3]} + {24'h0, rnd_up};
    rnd_e    = ne_r + $signed({9'h000, rnd_m[24]});
    rnd_frac = rnd_m[24] ? rnd_m[23:1] : rnd_m[22:0];
    rnd_ovf  = rnd_e >= 10'sd255;
    if (sp)                rnd_res = sp_res;
    else if (nzero || nuf) rnd_res = {r_sign, 31'h0};
    else if (rnd_ovf)      rnd_res = {r_sign, 8'hFF, 23'h0};
    else                   rnd_res = {r_sign, rnd_e[7:0], rnd_frac};
  end

  // Datapath pipeline registers. Each stage loads only while the FSM is in
  // that stage. Leftover contents after a reset are never used.
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: begin
        if (in_valid) begin
          a_r <= a;
          b_r <= {~b[31], b[30:0]};
        end
      end
      S_UNPACK: begin
        sa     <= a_r[31];
        sb     <= b_r[31];
        ea     <= ua_zero ? 8'h00  : ua_e;
        eb     <= ub_zero ? 8'h00  : ub_e;
        ma     <= ua_zero ? 24'h0  : {1'b1, a_r[22:0]};
        mb     <= ub_zero ? 24'h0  : {1'b1, b_r[22:0]};
        sp     <= up_sp;
        sp_res <= up_res;
      end
      S_ALIGN: begin
        s_big   <= a_ge ? sa : sb;
        s_small <= a_ge ? sb : sa;
        e_big   <= e_hi;
        m_big   <= {m_hi, 3'b000};
        m_small <= al_shifted | {26'h0, al_lost};
      end
      S_ADD: begin
        sum_r  <= add_sum;
        e_sum  <= e_big;
        r_sign <= (eff_sub && (add_sum == 28'h0)) ? 1'b0 : s_big;
      end
      S_NORM: begin
        nm_r  <= n_mant;
        ne_r  <= n_exp;
        nzero <= (sum_r == 28'h0);
        nuf   <= (sum_r != 28'h0) && (n_exp <= 10'sd0);
      end
      default: ;
    endcase
  end

  // Result register. Loaded once per operation and held through DONE until
  // the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst)                  out_r <= 32'h0;
    else if (state == S_ROUND) out_r <= rnd_res;
  end

  assign out = out_r;

`ifdef FP_SUB_FLAGS_EN
  // Exception flags travel with out. They clear on every accept so that a
  // stale flag never lines up with a new operation.
  logic [3:0] flags_r, rnd_flags;
  logic       f_inv, f_ovf, f_uf, f_inx;
  always_comb begin
    f_inv     = sp && (sp_res == QNAN);
    f_ovf     = !sp && !nzero && !nuf && rnd_ovf;
    f_uf      = !sp && nuf;
    f_inx     = !sp && !nzero && (f_ovf || (|nm_r[2:0]));
    rnd_flags = {f_inv, f_ovf, f_uf, f_inx};
  end

  always_ff @(posedge clk) begin
    if (rst)                                flags_r <= 4'h0;
    else if (state == S_IDLE && in_valid)   flags_r <= 4'h0;
    else if (state == S_ROUND)              flags_r <= rnd_flags;
  end

  assign flags = flags_r;
`endif

endmodule

// File: tb/tb_fp_sub_seq.sv
// Testbench for fp_sub_seq.
// - Directed operations are pushed into a scoreboard when they are driven.
// - Each expected value is popped and compared when the DUT presents its result.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, out;
`ifdef FP_SUB_FLAGS_EN
  logic [3:0]  flags;
`endif

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  flg_q[$];
  int          cyc;

  always #5 clk = ~clk;

  fp_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef FP_SUB_FLAGS_EN
    ,
    .flags     (flags)
`endif
  );

  // Single comparison point. Every check in the bench goes through here.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  // Drive one operand pair. The DUT accepts it on the next rising edge.
  // The expected result goes into the scoreboard at the same time.
  task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv,
                               input logic [31:0] ev, input logic [3:0] fv);
    @(negedge clk);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    checkVal("in_ready_at_accept", {31'h0, in_ready}, 32'd1);
    exp_q.push_back(ev);
    flg_q.push_back(fv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, with a bound. The cycle right after the accept
  // edge is numbered 1.
  task automatic waitValid(output int cycles);
    cycles = 1;
    while (out_valid !== 1'b1 && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Pop the oldest expected result and compare it against the DUT output.
  task automatic checkOutput(input string tag);
    logic [31:0] ev;
    logic [3:0]  fv;
    ev = 32'hDEAD_BEEF;
    fv = 4'hF;
    checkVal({tag, "_pending"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() != 0) begin
      ev = exp_q.pop_front();
      fv = flg_q.pop_front();
    end
    checkVal({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    checkVal({tag, "_out"}, out, ev);
`ifdef FP_SUB_FLAGS_EN
    checkVal({tag, "_flags"}, {28'h0, flags}, {28'h0, fv});
`else
    if (fv === 4'hF) $display("[TB] note: %s had no scoreboard entry", tag);
`endif
  endtask

  // Run one complete operation with out_ready high.
  // - Check the latency, the result, and the return to IDLE.
  task automatic runOp(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] ev, input logic [3:0] fv);
    int c;
    applyStimulus(av, bv, ev, fv);
    waitValid(c);
    checkVal({tag, "_latency"}, c, 32'd6);
    checkOutput(tag);
    @(posedge clk);
    #1;
    checkVal({tag, "_in_ready_after"}, {31'h0, in_ready}, 32'd1);
    checkVal({tag, "_valid_dropped"}, {31'h0, out_valid}, 32'd0);
  endtask

  // Watchdog, in case a handshake never completes.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'h0;
    b         = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("reset_in_ready", {31'h0, in_ready}, 32'd1);
    checkVal("reset_out_valid", {31'h0, out_valid}, 32'd0);
    checkVal("reset_out", out, 32'h0);
`ifdef FP_SUB_FLAGS_EN
    checkVal("reset_flags", {28'h0, flags}, 32'h0);
`endif

    // Basic subtraction, cancellation, rounding, and specials.
    runOp("t1_basic",       32'h4146_0000, 32'h40A0_0000, 32'h40EC_0000, 4'b0000);
    runOp("t2_equal",       32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 4'b0000);
    runOp("t2_cancel",      32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 4'b0000);
    runOp("t3_norm1",       32'h3F80_0000, 32'h3380_0000, 32'h3F7F_FFFF, 4'b0000);
    runOp("t3_tie_even",    32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 4'b0001);
    runOp("t4_inf_inf",     32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b1000);
    runOp("t4_overflow",    32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 4'b0101);
    runOp("neg0_minus_pos0",32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 4'b0000);
    runOp("pos0_minus_neg0",32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 4'b0000);
    runOp("inf_minus_fin",  32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'b0000);
    runOp("fin_minus_inf",  32'h3F80_0000, 32'h7F80_0000, 32'hFF80_0000, 4'b0000);
    runOp("nan_operand",    32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000);
    runOp("two_minus_one",  32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);
    runOp("one_minus_two",  32'h3F80_0000, 32'h4000_0000, 32'hBF80_0000, 4'b0000);

    // Consumer stall: the result must hold and new operands must be refused.
    @(negedge clk);
    out_ready = 1'b0;
    applyStimulus(32'h4146_0000, 32'h40A0_0000, 32'h40EC_0000, 4'b0000);
    waitValid(cyc);
    checkVal("t5_latency", cyc, 32'd6);
    checkOutput("t5_first");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a        = 32'h3F80_0000;
      b        = 32'h3F80_0000;
      @(posedge clk);
      #1;
      checkVal("t5_hold_valid", {31'h0, out_valid}, 32'd1);
      checkVal("t5_hold_out", out, 32'h40EC_0000);
      checkVal("t5_hold_in_ready", {31'h0, in_ready}, 32'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkVal("t5_release_valid", {31'h0, out_valid}, 32'd0);
    checkVal("t5_release_in_ready", {31'h0, in_ready}, 32'd1);
    repeat (8) @(posedge clk);
    #1;
    checkVal("t5_no_phantom_op", {31'h0, out_valid}, 32'd0);

    // Reset while the operation is in ALIGN. The in-flight op is discarded.
    applyStimulus(32'h4146_0000, 32'h40A0_0000, 32'h40EC_0000, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    flg_q.delete();
    checkVal("t6_rst_out_valid", {31'h0, out_valid}, 32'd0);
    checkVal("t6_rst_in_ready", {31'h0, in_ready}, 32'd1);
    checkVal("t6_rst_out", out, 32'h0);
`ifdef FP_SUB_FLAGS_EN
    checkVal("t6_rst_flags", {28'h0, flags}, 32'h0);
`endif
    runOp("t6_fresh",       32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
